// File: rtl/maverickOne_pkg.sv
// Shared core constants and types for the launch / register-lock path.
package maverickOne_pkg;

  localparam int unsigned NUM_REGS        = 64;
  localparam int unsigned NUM_OUTSTANDING = 4;
  localparam int unsigned RIDX_W          = $clog2(NUM_REGS);

  typedef logic [NUM_REGS-1:0] locks_t;

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/reg_lock_cnt.sv
// Per-register outstanding-write counter: +1 on launch, -k on writebacks, saturating at zero.
module reg_lock_cnt #(
  parameter int unsigned  MAX_PER_REG = 3,
  parameter int unsigned  NUM_WB      = 2,
  localparam int unsigned CNT_W       = $clog2(MAX_PER_REG + 1),
  localparam int unsigned DEC_W       = $clog2(NUM_WB + 1)
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [DEC_W-1:0] dec_count_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             locked_o,
  output logic             underflow_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      avail;

  // Increment and decrements are netted in one update so a same-cycle launch can absorb a wb.
  always_comb begin
    avail       = 32'(cnt_q) + 32'(inc_i);
    underflow_o = 32'(dec_count_i) > avail;
    cnt_d       = underflow_o ? '0 : CNT_W'(avail - 32'(dec_count_i));
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign locked_o = (cnt_q != '0);

endmodule

// File: rtl/reg_lock_tracker.sv
// Register-lock scoreboard: counts outstanding writes per register and in total.
// Define REG_LOCK_TRACKER_WB_BYPASS_EN to release locks in the same cycle as the final writeback.
module reg_lock_tracker
  import maverickOne_pkg::*;
#(
  parameter int unsigned  NUM_WB      = 2,
  parameter int unsigned  MAX_PER_REG = 3,
  localparam int unsigned CNT_W       = $clog2(MAX_PER_REG + 1),
  localparam int unsigned OUT_W       = $clog2(NUM_OUTSTANDING + 1),
  localparam int unsigned DEC_W       = $clog2(NUM_WB + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     launch_valid_i,
  output logic                     launch_ready_o,
  input  logic [RIDX_W-1:0]        launch_rd_i,
  input  logic                     launch_wr_i,
  input  logic [NUM_WB-1:0]        wb_valid_i,
  input  logic [NUM_WB*RIDX_W-1:0] wb_rd_i,
  output locks_t                   locks_o,
  output logic [OUT_W-1:0]         inflight_o,
  output logic                     idle_o,
  output logic                     error_o
);

  logic              flush;
  logic              eff_wr;
  logic              accept;
  logic [RIDX_W-1:0] wb_rd   [NUM_WB];
  logic [CNT_W-1:0]  cnt     [NUM_REGS];
  logic [DEC_W-1:0]  dec_cnt [NUM_REGS];
  locks_t            inc;
  locks_t            locked;
  locks_t            underflow;
  logic [OUT_W-1:0]  total_q, total_d;
  logic              err_q, err_d;

  assign flush  = rst_i | clear_i;
  assign eff_wr = launch_wr_i & (launch_rd_i != '0);

  // The per-register limit only matters when the launch actually locks something.
  assign launch_ready_o = ~flush & (total_q < OUT_W'(NUM_OUTSTANDING)) &
                          (~eff_wr | (cnt[launch_rd_i] < CNT_W'(MAX_PER_REG)));
  assign accept         = launch_valid_i & launch_ready_o & eff_wr;

  for (genvar p = 0; p < NUM_WB; p++) begin : g_wb
    assign wb_rd[p] = wb_rd_i[p*RIDX_W +: RIDX_W];
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      dec_cnt[r] = '0;
    end
    if (!flush) begin
      for (int p = 0; p < NUM_WB; p++) begin
        if (wb_valid_i[p] && (wb_rd[p] != '0)) begin
          dec_cnt[wb_rd[p]] = dec_cnt[wb_rd[p]] + DEC_W'(1);
        end
      end
    end
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
    assign inc[r] = accept & (launch_rd_i == RIDX_W'(r));

    reg_lock_cnt #(
      .MAX_PER_REG(MAX_PER_REG),
      .NUM_WB     (NUM_WB)
    ) u_cnt (
      .clk_i      (clk_i),
      .clr_i      (flush),
      .inc_i      (inc[r]),
      .dec_count_i(dec_cnt[r]),
      .cnt_o      (cnt[r]),
      .locked_o   (locked[r]),
      .underflow_o(underflow[r])
    );
  end

  // Total only loses what the per-register counters really removed, keeping total == sum(cnt).
  always_comb begin
    int unsigned removed;
    int unsigned avail;
    logic        first;
    removed = 0;
    avail   = 0;
    first   = 1'b0;
    for (int p = 0; p < NUM_WB; p++) begin
      first = wb_valid_i[p] && (wb_rd[p] != '0) && !flush;
      for (int q = 0; q < NUM_WB; q++) begin
        if ((q < p) && wb_valid_i[q] && (wb_rd[q] == wb_rd[p])) begin
          first = 1'b0;
        end
      end
      if (first) begin
        avail   = 32'(cnt[wb_rd[p]]) + 32'(inc[wb_rd[p]]);
        removed = removed + min_u(32'(dec_cnt[wb_rd[p]]), avail);
      end
    end
    total_d = OUT_W'(32'(total_q) + 32'(accept) - removed);
    err_d   = err_q | (|underflow);
  end

  always_ff @(posedge clk_i) begin
    if (flush) begin
      total_q <= '0;
      err_q   <= 1'b0;
    end else begin
      total_q <= total_d;
      err_q   <= err_d;
    end
  end

`ifdef REG_LOCK_TRACKER_WB_BYPASS_EN
  locks_t wb_clear_mask;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_bypass
    assign wb_clear_mask[r] = (dec_cnt[r] != '0) &&
                              (32'(dec_cnt[r]) >= 32'(cnt[r]) + 32'(inc[r]));
  end

  assign locks_o = locked & ~wb_clear_mask;
`else
  assign locks_o = locked;
`endif

  assign inflight_o = total_q;
  assign idle_o     = (total_q == '0);
  assign error_o    = err_q;

endmodule
